fft_sequencer: RTL
==================

FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 5, meaning log2 of FFT points (32).
REQ-002 SHALL have parameter NUMSTAGES, default 5, meaning radix-2 stage count, equal to ADDRSIZE.
REQ-003 SHALL have parameter BFLY_LAT, default 3, meaning butterfly read-to-write latency in cycles, range 1..7.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, all logic on posedge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: request one full FFT pass.
REQ-007 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted through the last WAIT cycle.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port stage_num, output, 3 bits: current stage s, 0..NUMSTAGES-1.
REQ-010 SHALL have port bfly_idx, output, ADDRSIZE-1 bits: butterfly index k within stage, 0..15.
REQ-011 SHALL have port ld_twiddle, output, 1 bit: twiddle ROM chip select.
REQ-012 SHALL have port tw_addr, output, ADDRSIZE bits: twiddle ROM address.
REQ-013 SHALL have ports rd_en (1 bit), rd_addr_a and rd_addr_b (ADDRSIZE bits each), outputs: data-memory read strobe and operand addresses.
REQ-014 SHALL have ports wr_en (1 bit), wr_addr_a and wr_addr_b (ADDRSIZE bits each), outputs: write-back strobe and result addresses.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, WAIT, DONE.
REQ-016 FSM SHALL go from IDLE to RUN when start=1, clearing s and k to 0; start SHALL be ignored in every other state.
REQ-017 RUN SHALL issue one butterfly per cycle with rd_en=ld_twiddle=1 and k incrementing; after k=15 the FSM SHALL enter WAIT.
REQ-018 WAIT SHALL last exactly BFLY_LAT cycles with rd_en=0, then go to RUN with s+1 and k=0, or to DONE if s=NUMSTAGES-1.
REQ-019 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-020 Address rules, with span=1<<s, grp=k>>s, pos=k&(span-1): rd_addr_a=(grp<<(s+1))|pos, rd_addr_b=rd_addr_a+span, tw_addr=pos<<(NUMSTAGES-1-s), all ADDRSIZE bits with no overflow.
REQ-021 All RUN outputs SHALL be registered and valid in the same cycle as rd_en; stage_num and bfly_idx SHALL track the issued butterfly.
REQ-022 wr_en, wr_addr_a and wr_addr_b SHALL equal rd_en, rd_addr_a and rd_addr_b delayed by exactly BFLY_LAT cycles via a shift pipeline.
REQ-023 No read of stage s+1 SHALL occur before the final write of stage s; the WAIT length guarantees this.
REQ-024 With BFLY_LAT=3, done SHALL assert 95 cycles (5*(16+3)) after the edge that samples start; busy=0 in IDLE and DONE.
REQ-025 Outside RUN, rd_addr_*, tw_addr and bfly_idx SHALL hold their last values while rd_en=ld_twiddle=0.

Reset
REQ-026 rst=1 SHALL force IDLE, s=k=0, clear the write pipeline, and drive every output to 0 on the next edge.
REQ-027 rst mid-pass SHALL cancel all pending writes, so wr_en=0 from the cycle after rst, and SHALL produce no done pulse.
REQ-028 rst SHALL take priority over start in the same cycle.

Structure
REQ-029 State encodings (IDLE/RUN/WAIT/DONE) and stage constants STAGE0..STAGE4 SHALL live in shared package fft_pkg.
REQ-030 The BFLY_LAT delay line SHALL be sub-module fft_delay_line (parameterized width and depth); the address arithmetic SHALL stay inline.

Verification
REQ-031 start pulse in IDLE -> 80 rd_en cycles and 80 wr_en cycles, with done at +95 cycles and busy high for 94 cycles.
REQ-032 s=0, k=5 -> rd_addr_a=10, rd_addr_b=11, tw_addr=0; s=2, k=5 -> 9, 13, 4.
REQ-033 s=3, k=9 -> rd_addr_a=17, rd_addr_b=25, tw_addr=2; s=4, k=15 -> 15, 31, 15.
REQ-034 wr_addr_a/wr_addr_b SHALL equal rd_addr_a/rd_addr_b from exactly 3 cycles earlier, and no read of stage s+1 SHALL precede the last write of stage s.
REQ-035 rst at cycle 40 of a pass -> all outputs 0 next cycle, no further wr_en, no done; a new start then runs a full clean pass.
REQ-036 start held high continuously and start asserted during DONE -> no restart until IDLE; the back-to-back pass begins exactly one cycle after done.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 FFT sequencer.
// State encodings and stage numbers used across the FFT slice.
package fft_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [2:0] STAGE0 = 3'd0;
   localparam logic [2:0] STAGE1 = 3'd1;
   localparam logic [2:0] STAGE2 = 3'd2;
   localparam logic [2:0] STAGE3 = 3'd3;
   localparam logic [2:0] STAGE4 = 3'd4;

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift pipeline; matches butterfly read-to-write latency.
// Synchronous reset flushes every slot so pending writes are dropped.
module fft_delay_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] pipe [DEPTH];

   // shift one slot per cycle, clear all slots on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= din;
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/fft_sequencer.sv
// In-place radix-2 FFT address sequencer: one butterfly per cycle,
// a latency-sized gap between stages, write-back via a delay line.
module fft_sequencer
   import fft_pkg::*;
#(
   parameter int ADDRSIZE  = 5,
   parameter int NUMSTAGES = 5,
   parameter int BFLY_LAT  = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [2:0]          stage_num,
   output logic [ADDRSIZE-2:0] bfly_idx,
   output logic                ld_twiddle,
   output logic [ADDRSIZE-1:0] tw_addr,
   output logic                rd_en,
   output logic [ADDRSIZE-1:0] rd_addr_a,
   output logic [ADDRSIZE-1:0] rd_addr_b,
   output logic                wr_en,
   output logic [ADDRSIZE-1:0] wr_addr_a,
   output logic [ADDRSIZE-1:0] wr_addr_b
);

   localparam logic [ADDRSIZE-2:0] LAST_K = '1;
   localparam logic [2:0]          LAST_S = 3'(NUMSTAGES - 1);
   localparam logic [2:0]          LAST_W = 3'(BFLY_LAT - 1);
   localparam int                  PW     = 2 * ADDRSIZE + 1;

   state_t              state;
   logic [2:0]          s;
   logic [ADDRSIZE-2:0] k;
   logic [2:0]          wcnt;

   logic [2:0]          iss_s;
   logic [ADDRSIZE-2:0] iss_k;
   logic [ADDRSIZE-1:0] kx, span, grp, pos;
   logic [ADDRSIZE-1:0] iss_a, iss_b, iss_tw;

   logic [PW-1:0]       pipe_in, pipe_out;

   // butterfly that would be issued at the coming edge, and its addresses
   always_comb begin
      iss_s = STAGE0;
      iss_k = '0;
      if (state == RUN) begin
         iss_s = s;
         iss_k = k + 1'b1;
      end else if (state == WAIT) begin
         iss_s = s + 3'd1;
      end
      kx     = {1'b0, iss_k};
      span   = ADDRSIZE'(1) << iss_s;
      grp    = kx >> iss_s;
      pos    = kx & (span - 1'b1);
      iss_a  = (grp << (iss_s + 3'd1)) | pos;
      iss_b  = iss_a + span;
      iss_tw = pos << (LAST_S - iss_s);
   end

   // control FSM with registered strobes; busy rises one cycle after
   // the first issue and drops as the last WAIT cycle hands over to DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         s          <= STAGE0;
         k          <= '0;
         wcnt       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         stage_num  <= '0;
         bfly_idx   <= '0;
         ld_twiddle <= 1'b0;
         tw_addr    <= '0;
         rd_en      <= 1'b0;
         rd_addr_a  <= '0;
         rd_addr_b  <= '0;
      end else begin
         done       <= 1'b0;
         rd_en      <= 1'b0;
         ld_twiddle <= 1'b0;
         unique case (state)
            IDLE: begin
               busy <= 1'b0;
               if (start) begin
                  state      <= RUN;
                  s          <= iss_s;
                  k          <= iss_k;
                  rd_en      <= 1'b1;
                  ld_twiddle <= 1'b1;
                  stage_num  <= iss_s;
                  bfly_idx   <= iss_k;
                  rd_addr_a  <= iss_a;
                  rd_addr_b  <= iss_b;
                  tw_addr    <= iss_tw;
               end
            end
            RUN: begin
               busy <= 1'b1;
               if (k == LAST_K) begin
                  state <= WAIT;
                  wcnt  <= '0;
               end else begin
                  k          <= iss_k;
                  rd_en      <= 1'b1;
                  ld_twiddle <= 1'b1;
                  bfly_idx   <= iss_k;
                  rd_addr_a  <= iss_a;
                  rd_addr_b  <= iss_b;
                  tw_addr    <= iss_tw;
               end
            end
            WAIT: begin
               if (wcnt != LAST_W) begin
                  wcnt <= wcnt + 3'd1;
               end else if (s == LAST_S) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  state      <= RUN;
                  s          <= iss_s;
                  k          <= iss_k;
                  rd_en      <= 1'b1;
                  ld_twiddle <= 1'b1;
                  stage_num  <= iss_s;
                  bfly_idx   <= iss_k;
                  rd_addr_a  <= iss_a;
                  rd_addr_b  <= iss_b;
                  tw_addr    <= iss_tw;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign pipe_in = {rd_en, rd_addr_a, rd_addr_b};

   fft_delay_line #(
      .WIDTH(PW),
      .DEPTH(BFLY_LAT)
   ) u_wr_pipe (
      .clk (clk),
      .rst (rst),
      .din (pipe_in),
      .dout(pipe_out)
   );

   assign {wr_en, wr_addr_a, wr_addr_b} = pipe_out;

endmodule
